// File: rtl/detection_sm_pkg.sv
// Shared types and sizing for the detection_sm window-scan controller.
// Default frame geometry lives here so the grid size can be derived in one place.
package detect_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    WAIT,
    GAP,
    ADV
  } state_t;

  localparam int ADDR_W  = 15;
  localparam int COORD_W = 8;
  localparam int CNT_W   = 16;

  localparam int DEF_IMG_W = 160;
  localparam int DEF_IMG_H = 120;
  localparam int DEF_WIN   = 24;
  localparam int DEF_STEP  = 4;

  // Number of window positions along one axis.
  function automatic int grid_n(input int extent, input int win, input int step);
    return (extent - win) / step + 1;
  endfunction

  localparam int NX = grid_n(DEF_IMG_W, DEF_WIN, DEF_STEP);
  localparam int NY = grid_n(DEF_IMG_H, DEF_WIN, DEF_STEP);

endpackage

// File: rtl/detection_sm_if.sv
// Classifier handshake: the controller (master) presents a window and
// requests a run; the classifier (slave) answers with done and a result.
interface detection_sm_if;
  import detect_pkg::*;

  logic              detect_en;
  logic              detect_done;
  logic              detected_flag;
  logic [ADDR_W-1:0] win_base;

  modport master (
    output detect_en,
    output win_base,
    input  detect_done,
    input  detected_flag
  );

  modport slave (
    input  detect_en,
    input  win_base,
    output detect_done,
    output detected_flag
  );

endinterface

// File: rtl/detection_sm_window_stepper.sv
// Raster-order window position (x fastest) and the registered buffer address
// of the window's top-left pixel.
module window_stepper
  import detect_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int WIN   = DEF_WIN,
  parameter int STEP  = DEF_STEP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               step_i,
  output logic [COORD_W-1:0] win_x_o,
  output logic [COORD_W-1:0] win_y_o,
  output logic [ADDR_W-1:0]  win_base_o,
  output logic               last_o
);

  localparam int XMAX = (grid_n(IMG_W, WIN, STEP) - 1) * STEP;
  localparam int YMAX = (grid_n(IMG_H, WIN, STEP) - 1) * STEP;

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [ADDR_W-1:0]  base_q, base_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (step_i) begin
      if (x_q == COORD_W'(XMAX)) begin
        x_d = '0;
        y_d = y_q + COORD_W'(STEP);
      end else begin
        x_d = x_q + COORD_W'(STEP);
      end
    end
    // Full-width product, then truncated to the buffer address width.
    base_d = ADDR_W'(32'(y_d) * IMG_W + 32'(x_d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      base_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      base_q <= base_d;
    end
  end

  assign win_x_o    = x_q;
  assign win_y_o    = y_q;
  assign win_base_o = base_q;
  assign last_o     = (x_q == COORD_W'(XMAX)) && (y_q == COORD_W'(YMAX));

endmodule

// File: rtl/detection_sm.sv
// Classifier initiator: scans a WIN x WIN window over each frame and reports hits.
// Optional watchdog on the WAIT state is enabled by defining DETECT_WDOG_EN.
module detection_sm
  import detect_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int WIN     = DEF_WIN,
  parameter int STEP    = DEF_STEP,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  detection_sm_if.master        cls,
  output logic                  hit_valid,
  output logic [COORD_W-1:0]    hit_x,
  output logic [COORD_W-1:0]    hit_y,
  output logic [CNT_W-1:0]      hit_count,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  timeout_err
);

  state_t             state_q, state_d;
  logic               detect_en_q, detect_en_d;
  logic               hit_valid_q, hit_valid_d;
  logic [COORD_W-1:0] hit_x_q, hit_x_d, hit_y_q, hit_y_d;
  logic [CNT_W-1:0]   hit_count_q, hit_count_d;
  logic               frame_done_q, frame_done_d;
  logic               clear, step, last;
  logic [COORD_W-1:0] win_x, win_y;

`ifdef DETECT_WDOG_EN
  logic [CNT_W-1:0]   wdog_q, wdog_d;
  logic               timeout_q, timeout_d;
`endif

  window_stepper #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .STEP(STEP)
  ) u_stepper (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear),
    .step_i     (step),
    .win_x_o    (win_x),
    .win_y_o    (win_y),
    .win_base_o (cls.win_base),
    .last_o     (last)
  );

  always_comb begin
    state_d      = state_q;
    hit_valid_d  = 1'b0;
    hit_x_d      = hit_x_q;
    hit_y_d      = hit_y_q;
    hit_count_d  = hit_count_q;
    frame_done_d = 1'b0;
    clear        = 1'b0;
    step         = 1'b0;
`ifdef DETECT_WDOG_EN
    wdog_d       = '0;
    timeout_d    = timeout_q;
`endif
    unique case (state_q)
      IDLE: if (frame_start) begin
        hit_count_d = '0;
        clear       = 1'b1;
        state_d     = RUN;
      end
      RUN: state_d = WAIT;
      WAIT: begin
        if (cls.detect_done) begin
          state_d = GAP;
          if (cls.detected_flag) begin
            hit_valid_d = 1'b1;
            hit_x_d     = win_x;
            hit_y_d     = win_y;
            if (hit_count_q != '1) hit_count_d = hit_count_q + 1'b1;
          end
        end
`ifdef DETECT_WDOG_EN
        // Expiry counts as a negative window; GAP still waits for done low.
        else if (wdog_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = GAP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      // Guarantees detect_en is low for at least one cycle between runs.
      GAP: if (!cls.detect_done) state_d = ADV;
      ADV: begin
        if (last) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          step    = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    detect_en_d = (state_d == WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      detect_en_q  <= 1'b0;
      hit_valid_q  <= 1'b0;
      hit_x_q      <= '0;
      hit_y_q      <= '0;
      hit_count_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      detect_en_q  <= detect_en_d;
      hit_valid_q  <= hit_valid_d;
      hit_x_q      <= hit_x_d;
      hit_y_q      <= hit_y_d;
      hit_count_q  <= hit_count_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef DETECT_WDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_err = timeout_q;
`else
  // TIMEOUT is always positive, so this is a constant 0.
  assign timeout_err = (TIMEOUT < 0);
`endif

  assign cls.detect_en = detect_en_q;
  assign hit_valid     = hit_valid_q;
  assign hit_x         = hit_x_q;
  assign hit_y         = hit_y_q;
  assign hit_count     = hit_count_q;
  assign frame_done    = frame_done_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: doc/detection_sm.md
Name: detection_sm

Overview:
- Initiator side of the detect_en / detect_done classifier handshake.
- On each frame, steps a WIN x WIN window across the frame buffer at STEP-pixel stride, one classifier run per window.
- Presents each window's base address, collects detected_flag, and reports hits and a per-frame hit count.
- Sits between the frame buffer writer (frame_start) and the classifier; downstream logic consumes hits.

Parameters:
- IMG_W, 160, frame width in pixels
- IMG_H, 120, frame height in pixels
- WIN, 24, window side in pixels; must be <= IMG_W and <= IMG_H
- STEP, 4, window stride in pixels, both axes
- TIMEOUT, 4096, cycle limit in WAIT; used only with DETECT_WDOG_EN

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frame_start  in  1  one-cycle pulse: frame buffer holds a complete frame
- detect_en  out  1  to classifier: run classification on the current window; level signal
- detect_done  in  1  from classifier: run finished; held high until detect_en falls
- detected_flag  in  1  from classifier: result, valid while detect_done=1
- win_base  out  15  buffer address of the window's top-left pixel: win_y*IMG_W+win_x
- hit_valid  out  1  one-cycle pulse: current window classified positive
- hit_x  out  8  window x of the hit; valid with hit_valid
- hit_y  out  8  window y of the hit; valid with hit_valid
- hit_count  out  16  positives in the current/last frame
- frame_done  out  1  one-cycle pulse: last window finished
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky; set by watchdog expiry (tied 0 without DETECT_WDOG_EN)

Behaviour:
- Reset: state=IDLE; all outputs 0; win_x=win_y=0.
- Reset mid-scan: detect_en is 0 after the same edge; the scan is abandoned.
- Window grid:
  - x takes 0, STEP, ... up to the largest value <= IMG_W-WIN; y likewise with IMG_H.
  - Defaults: 35 x 25 = 875 windows.
  - Scan is raster order: x fastest, then y.
- win_base is registered from win_x/win_y and is stable for the whole time detect_en=1.
- States:
  - IDLE: frame_start=1 -> clear hit_count, win_x=win_y=0 -> RUN. frame_start is ignored in all other states.
  - RUN: detect_en<=1 -> WAIT.
  - WAIT: detect_en held 1; on detect_done=1 -> sample detected_flag -> detect_en<=0 -> GAP.
    - If the flag is 1: hit_valid=1 for one cycle with hit_x/hit_y = current window, and hit_count+1.
    - hit_count saturates at 0xFFFF.
  - GAP: detect_en=0; stay until detect_done=0. This guarantees at least one low cycle, so the classifier sees a fresh rising edge. -> ADV.
  - ADV:
    - last window -> frame_done=1 for one cycle -> IDLE.
    - otherwise update win_x/win_y and win_base -> RUN.
- Overhead per window: exactly 3 controller cycles (RUN, GAP min 1, ADV) beyond the classifier's detect_done latency.
- detect_done=1 in any state other than WAIT is ignored. detected_flag is only sampled in WAIT.
- hit_count holds its value in IDLE until the next frame_start.
- Address arithmetic: win_y*IMG_W+win_x, computed at full width, then truncated to 15 bits. Defaults need at most 19199 < 2^15.

Optional Feature:
- Macro: DETECT_WDOG_EN.
- Defined:
  - A 16-bit counter runs in WAIT.
  - On reaching TIMEOUT with no detect_done: set timeout_err (sticky until rst), treat the window as negative, go to GAP.
  - GAP still waits for detect_done=0.
- Undefined:
  - No counter; WAIT waits indefinitely.
  - timeout_err is constant 0.

Decomposition:
- Package detect_pkg:
  - state enum (IDLE, RUN, WAIT, GAP, ADV)
  - ADDR_W=15, COORD_W=8, CNT_W=16
  - derived localparams: NX=(IMG_W-WIN)/STEP+1, NY=(IMG_H-WIN)/STEP+1
- Sub-module window_stepper:
  - holds win_x/win_y and win_base
  - inputs clear and step; output last
  - keeps the address arithmetic out of the FSM

Test Plan:
- Classifier model: toggling result (positive on odd runs), 16-cycle delay, defaults. One frame_start -> 875 detect_en rising edges; hits at window indices 0,2,...,874; hit_count=438; exactly one frame_done pulse.
- Address check, same frame: the 36th window (index 35) has win_base=4*160+0=640; the last window has win_base=96*160+136=15496; win_base is stable while detect_en=1.
- frame_start pulsed again mid-scan -> ignored; total windows stays 875; busy=1 throughout.
- Model holds detect_done high 5 extra cycles after detect_en falls -> controller stays in GAP; detect_en does not re-rise until 1 cycle after detect_done=0.
- rst asserted during WAIT at window 100 -> next cycle detect_en=0, hit_count=0, busy=0; a following frame_start restarts at win_base=0.
- DETECT_WDOG_EN with TIMEOUT=64 and a model that never asserts detect_done on window 3 -> timeout_err=1 after 64 WAIT cycles, no hit for window 3, and the scan completes.
